// File: rtl/sub_pe_ctrl_if.sv
// sub_pe_ctrl_if: groups the job request, buffer read, sub_pe drive and
// result handshake signals of the sub_pe_ctrl job sequencer.
//   slave  : controller side (sub_pe_ctrl)
//   master : environment side (job source, buffers, sub_pe, result sink)
// Signals:
//   job_valid/job_ready, job_channel, job_img_base, job_wgt_base : job request
//   mem_rd_en, img_addr, wgt_addr                                : buffer reads
//   pe_start, pe_channel, pe_result                              : sub_pe lane
//   res_valid/res_ready, res_data                                : result port
//   busy                                                         : status
interface sub_pe_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 20
);
  logic              job_valid;
  logic              job_ready;
  logic [2:0]        job_channel;
  logic [ADDR_W-1:0] job_img_base;
  logic [ADDR_W-1:0] job_wgt_base;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] img_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic              pe_start;
  logic [2:0]        pe_channel;
  logic [ACC_W-1:0]  pe_result;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              busy;

  modport slave (
    input  job_valid, job_channel, job_img_base, job_wgt_base, pe_result, res_ready,
    output job_ready, mem_rd_en, img_addr, wgt_addr, pe_start, pe_channel,
           res_valid, res_data, busy
  );

  modport master (
    output job_valid, job_channel, job_img_base, job_wgt_base, pe_result, res_ready,
    input  job_ready, mem_rd_en, img_addr, wgt_addr, pe_start, pe_channel,
           res_valid, res_data, busy
  );
endinterface

// File: rtl/sub_pe_ctrl.sv
// sub_pe_ctrl: job sequencer for one sub_pe multiply-accumulate lane.
// Accepts a job, streams N = channel+1 img/weight operand pairs out of two
// 1-cycle-latency buffers, pulses pe_start with the first pair arriving at
// sub_pe, waits PE_LAT+1 cycles for the pipeline to drain, then holds the
// captured result on a valid/ready port.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sub_pe_ctrl_if.slave (job, buffer, sub_pe and result signals)
//   perf_jobs, perf_busy_cyc : saturating counters, only when the macro
//              SUB_PE_CTRL_PERF_EN is defined
//
// state | meaning
// IDLE  | waiting for a job, job_ready=1
// FETCH | issuing N buffer reads, one per cycle
// DRAIN | waiting for last read + PE_LAT for pe_result to settle
// HOLD  | res_valid high until res_ready
module sub_pe_ctrl #(
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 20,
  parameter int PE_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  sub_pe_ctrl_if.slave bus
`ifdef SUB_PE_CTRL_PERF_EN
  ,
  output logic [15:0] perf_jobs,
  output logic [31:0] perf_busy_cyc
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;
  // one extra cycle covers the last buffer read landing at sub_pe
  localparam logic [4:0]        DRAIN_LOAD = 5'(PE_LAT + 1);

  logic [1:0] state;
  logic [2:0] k;
  logic [4:0] drain_cnt;

  assign bus.job_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      k              <= '0;
      drain_cnt      <= '0;
      bus.mem_rd_en  <= 1'b0;
      bus.img_addr   <= '0;
      bus.wgt_addr   <= '0;
      bus.pe_start   <= 1'b0;
      bus.pe_channel <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
    end else begin
      bus.pe_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.job_valid) begin
            bus.pe_channel <= bus.job_channel;
            bus.img_addr   <= bus.job_img_base;
            bus.wgt_addr   <= bus.job_wgt_base;
            bus.mem_rd_en  <= 1'b1;
            k              <= '0;
            state          <= S_FETCH;
          end
        end
        S_FETCH: begin
          // first read returns next cycle, so start lines up with it
          bus.pe_start <= (k == 3'd0);
          if (k == bus.pe_channel) begin
            bus.mem_rd_en <= 1'b0;
            drain_cnt     <= DRAIN_LOAD;
            state         <= S_DRAIN;
          end else begin
            k            <= k + 3'd1;
            bus.img_addr <= bus.img_addr + ADDR_ONE;
            bus.wgt_addr <= bus.wgt_addr + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 5'd1) begin
            bus.res_data  <= bus.pe_result[ACC_W-1:0];
            bus.res_valid <= 1'b1;
            state         <= S_HOLD;
          end else begin
            drain_cnt <= drain_cnt - 5'd1;
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SUB_PE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jobs     <= '0;
      perf_busy_cyc <= '0;
    end else begin
      if (bus.busy && (perf_busy_cyc != '1))
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if ((state == S_HOLD) && bus.res_ready && (perf_jobs != '1))
        perf_jobs <= perf_jobs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_pe_ctrl.sv
module tb_sub_pe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  sub_pe_ctrl_if #(.ADDR_W(8), .ACC_W(20)) bus ();

`ifdef SUB_PE_CTRL_PERF_EN
  logic [15:0] perf_jobs;
  logic [31:0] perf_busy_cyc;
`endif

  sub_pe_ctrl #(.ADDR_W(8), .ACC_W(20), .PE_LAT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SUB_PE_CTRL_PERF_EN
    ,
    .perf_jobs(perf_jobs),
    .perf_busy_cyc(perf_busy_cyc)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drives one job for exactly one cycle; returns 1ns after the acceptance edge
  task automatic accept_job(input logic [2:0] ch, input logic [7:0] ib, input logic [7:0] wb);
    bus.job_valid    = 1'b1;
    bus.job_channel  = ch;
    bus.job_img_base = ib;
    bus.job_wgt_base = wb;
    step();
    bus.job_valid    = 1'b0;
    bus.job_channel  = 3'd7;
    bus.job_img_base = 8'hFF;
    bus.job_wgt_base = 8'hFF;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.mem_rd_en, bus.pe_start, bus.res_valid, bus.busy} !== 4'b0 ||
        bus.img_addr !== 8'h00 || bus.wgt_addr !== 8'h00 || bus.pe_channel !== 3'd0 ||
        bus.res_data !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: rd=%b st=%b rv=%b busy=%b ia=%h wa=%h ch=%0d rd=%h, required all 0",
               bus.mem_rd_en, bus.pe_start, bus.res_valid, bus.busy, bus.img_addr,
               bus.wgt_addr, bus.pe_channel, bus.res_data);
    end
    total++;
    if (bus.job_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_job_ready: got %b required 1", bus.job_ready);
    end
  endtask

  task automatic test_basic();
    int rd_cnt = 0;
    int st_cnt = 0;
    int first_valid = -1;
    bus.res_ready = 1'b0;
    bus.pe_result = 20'h11111;
    accept_job(3'd3, 8'h10, 8'h20);
    total++;
    if (bus.pe_channel !== 3'd3) begin
      bad++;
      $display("FAIL basic_pe_channel: got %0d required 3", bus.pe_channel);
    end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      total++;
      if (bus.mem_rd_en !== (c < 4)) begin
        bad++;
        $display("FAIL basic_rd_en c=%0d: got %b required %b", c, bus.mem_rd_en, (c < 4));
      end
      if (bus.mem_rd_en === 1'b1) begin
        rd_cnt++;
        total++;
        if (bus.img_addr !== 8'(8'h10 + c) || bus.wgt_addr !== 8'(8'h20 + c)) begin
          bad++;
          $display("FAIL basic_addr c=%0d: got %h/%h required %h/%h", c, bus.img_addr,
                   bus.wgt_addr, 8'(8'h10 + c), 8'(8'h20 + c));
        end
      end
      if (bus.pe_start === 1'b1) st_cnt++;
      total++;
      if (bus.pe_start !== (c == 1)) begin
        bad++;
        $display("FAIL basic_pe_start c=%0d: got %b required %b", c, bus.pe_start, (c == 1));
      end
      if (bus.res_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (c == 6) bus.pe_result = 20'hABCDE;
      if (c == 7) bus.pe_result = 20'h22222;
    end
    total++;
    if (rd_cnt != 4 || st_cnt != 1) begin
      bad++;
      $display("FAIL basic_counts: reads=%0d starts=%0d required 4 and 1", rd_cnt, st_cnt);
    end
    total++;
    if (first_valid != 7) begin
      bad++;
      $display("FAIL basic_latency: got %0d required 7", first_valid);
    end
    total++;
    if (bus.res_data !== 20'hABCDE) begin
      bad++;
      $display("FAIL basic_res_data: got %h required abcde", bus.res_data);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    total++;
    if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_handshake: rv=%b jr=%b busy=%b required 0 1 0",
               bus.res_valid, bus.job_ready, bus.busy);
    end
  endtask

  task automatic test_min_job();
    int rd_cnt = 0;
    int st_cnt = 0;
    int first_valid = -1;
    bus.res_ready = 1'b1;
    bus.pe_result = 20'h00777;
    accept_job(3'd0, 8'h30, 8'h40);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      if (bus.mem_rd_en === 1'b1) begin
        rd_cnt++;
        total++;
        if (bus.img_addr !== 8'h30 || bus.wgt_addr !== 8'h40) begin
          bad++;
          $display("FAIL min_addr: got %h/%h required 30/40", bus.img_addr, bus.wgt_addr);
        end
      end
      if (bus.pe_start === 1'b1) st_cnt++;
      if (bus.res_valid === 1'b1 && first_valid < 0) begin
        first_valid = c;
        total++;
        if (bus.res_data !== 20'h00777) begin
          bad++;
          $display("FAIL min_res_data: got %h required 00777", bus.res_data);
        end
      end
    end
    total++;
    if (rd_cnt != 1 || st_cnt != 1) begin
      bad++;
      $display("FAIL min_counts: reads=%0d starts=%0d required 1 and 1", rd_cnt, st_cnt);
    end
    total++;
    if (first_valid != 4) begin
      bad++;
      $display("FAIL min_latency: got %0d required 4", first_valid);
    end
    total++;
    if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
      bad++;
      $display("FAIL min_done: rv=%b jr=%b required 0 1", bus.res_valid, bus.job_ready);
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_img [4];
    int idx = 0;
    exp_img[0] = 8'hFE; exp_img[1] = 8'hFF; exp_img[2] = 8'h00; exp_img[3] = 8'h01;
    bus.res_ready = 1'b1;
    accept_job(3'd3, 8'hFE, 8'hFD);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      if (bus.mem_rd_en === 1'b1 && idx < 4) begin
        total++;
        if (bus.img_addr !== exp_img[idx] || bus.wgt_addr !== 8'(8'hFD + idx)) begin
          bad++;
          $display("FAIL wrap_addr %0d: got %h/%h required %h/%h", idx, bus.img_addr,
                   bus.wgt_addr, exp_img[idx], 8'(8'hFD + idx));
        end
        idx++;
      end
    end
    total++;
    if (idx != 4 || bus.job_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_done: reads=%0d jr=%b required 4 1", idx, bus.job_ready);
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int waited = 0;
    bus.res_ready = 1'b0;
    bus.pe_result = 20'h12345;
    accept_job(3'd2, 8'h50, 8'h60);
    while (bus.res_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    total++;
    if (waited != 6) begin
      bad++;
      $display("FAIL bp_latency: got %0d required 6", waited);
    end
    bus.pe_result = 20'h54321;
    bus.job_valid = 1'b1;
    bus.job_channel = 3'd1;
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 20'h12345 || bus.job_ready !== 1'b0 ||
          bus.mem_rd_en !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold c=%0d: rv=%b data=%h jr=%b rd=%b required 1 12345 0 0",
                 c, bus.res_valid, bus.res_data, bus.job_ready, bus.mem_rd_en);
      end
    end
    bus.job_valid = 1'b0;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    total++;
    if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: rv=%b jr=%b required 0 1", bus.res_valid, bus.job_ready);
    end
    step();
    total++;
    if (bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_second_job: rd=%b busy=%b required 0 0", bus.mem_rd_en, bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    int rd_cnt = 0;
    int first_valid = -1;
    bus.res_ready = 1'b1;
    accept_job(3'd7, 8'h00, 8'h80);
    step();
    rst = 1'b1;
    #1;
    total++;
    if ({bus.mem_rd_en, bus.pe_start, bus.res_valid, bus.busy} !== 4'b0 ||
        bus.img_addr !== 8'h00 || bus.wgt_addr !== 8'h00 || bus.pe_channel !== 3'd0 ||
        bus.res_data !== 20'h0 || bus.job_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_outputs: rd=%b st=%b rv=%b busy=%b ia=%h wa=%h ch=%0d jr=%b",
               bus.mem_rd_en, bus.pe_start, bus.res_valid, bus.busy, bus.img_addr,
               bus.wgt_addr, bus.pe_channel, bus.job_ready);
    end
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (bus.res_valid === 1'b1 || bus.mem_rd_en === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrst_no_result: activity cycles=%0d required 0", seen);
    end
    bus.pe_result = 20'h0BEEF;
    accept_job(3'd1, 8'h70, 8'h90);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      if (bus.mem_rd_en === 1'b1) rd_cnt++;
      if (bus.res_valid === 1'b1 && first_valid < 0) begin
        first_valid = c;
        total++;
        if (bus.res_data !== 20'h0BEEF) begin
          bad++;
          $display("FAIL midrst_new_data: got %h required 0beef", bus.res_data);
        end
      end
    end
    total++;
    if (rd_cnt != 2 || first_valid != 5) begin
      bad++;
      $display("FAIL midrst_new_job: reads=%0d latency=%0d required 2 and 5", rd_cnt, first_valid);
    end
    bus.res_ready = 1'b0;
  endtask

`ifdef SUB_PE_CTRL_PERF_EN
  task automatic test_perf();
    int waited;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    bus.res_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      accept_job(3'd1, 8'h00, 8'h00);
      waited = 0;
      while (bus.job_ready !== 1'b1 && waited < 20) begin
        step();
        waited++;
      end
      total++;
      if (waited != 6) begin
        bad++;
        $display("FAIL perf_job_len %0d: got %0d required 6", j, waited);
      end
    end
    step();
    step();
    total++;
    if (perf_jobs !== 16'd3) begin
      bad++;
      $display("FAIL perf_jobs: got %0d required 3", perf_jobs);
    end
    total++;
    if (perf_busy_cyc !== 32'd18) begin
      bad++;
      $display("FAIL perf_busy_cyc: got %0d required 18", perf_busy_cyc);
    end
    bus.res_ready = 1'b0;
  endtask
`endif

  initial begin
    bus.job_valid    = 1'b0;
    bus.job_channel  = 3'd0;
    bus.job_img_base = 8'h00;
    bus.job_wgt_base = 8'h00;
    bus.pe_result    = 20'h0;
    bus.res_ready    = 1'b0;
    #1;
    test_reset();
    step();
    rst = 1'b0;
    step();
    test_basic();
    step();
    test_min_job();
    step();
    test_wrap();
    step();
    test_backpressure();
    step();
    test_mid_reset();
`ifdef SUB_PE_CTRL_PERF_EN
    step();
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sub_pe_ctrl.md
Name: sub_pe_ctrl

Overview:
Job sequencer for one sub_pe multiply-accumulate lane. Accepts a job (channel count, image base address, weight base address) over a valid/ready handshake. Streams img/weight operand pairs from two 1-cycle-latency buffers into sub_pe, pulsing sub_pe's start on the first pair. After pipeline drain it captures the accumulated result and presents it on a valid/ready result port.

Parameters:
ADDR_W, 8, width of img/weight buffer read addresses
ACC_W, 20, width of the sub_pe accumulated result and res_data
PE_LAT, 2, cycles from sub_pe's last operand to a stable pe_result (legal 1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
job_valid  input  1  job request present
job_ready  output  1  controller can accept a job (high only in IDLE)
job_channel  input  3  operand pair count minus one (0 gives 1 pair, 7 gives 8 pairs)
job_img_base  input  ADDR_W  first image buffer address
job_wgt_base  input  ADDR_W  first weight buffer address
mem_rd_en  output  1  read strobe to both buffers
img_addr  output  ADDR_W  image buffer read address
wgt_addr  output  ADDR_W  weight buffer read address
pe_start  output  1  one-cycle pulse to sub_pe.start, aligned with first operand pair at sub_pe input
pe_channel  output  3  registered job_channel, driven to sub_pe.channel for the whole job
pe_result  input  ACC_W  sub_pe accumulated output
res_valid  output  1  res_data holds a finished result
res_ready  input  1  result consumer accepts
res_data  output  ACC_W  captured result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE. job_ready=1. All other outputs 0, including mem_rd_en, pe_start, res_valid, busy, addresses, pe_channel and res_data. Counters cleared.
- Reset asserted mid-job aborts the job immediately. No result is produced. The first post-reset cycle is IDLE.
- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE: on job_valid && job_ready, latch job_channel into pe_channel. Load the address registers with the bases. Load k=0 and N=job_channel+1. Go to FETCH.
- FETCH (N cycles):
  - mem_rd_en=1, img_addr=img_base+k, wgt_addr=wgt_base+k, k increments each cycle.
  - Address addition wraps modulo 2^ADDR_W (e.g. base 8'hFE, N=4 gives FE, FF, 00, 01).
  - After the cycle with k=N-1, go to DRAIN.
- pe_start: high exactly one cycle, the cycle after the first FETCH cycle (buffer read latency is 1). It is never asserted in any other cycle.
- DRAIN:
  - A down-counter loads PE_LAT+1 on entry. This covers the last buffer read landing plus PE_LAT.
  - At count 1, res_data<=pe_result, res_valid<=1, go to HOLD.
  - No mem_rd_en in DRAIN.
- HOLD:
  - res_valid and res_data stay stable until res_ready.
  - On res_valid && res_ready: res_valid<=0, go to IDLE. job_ready rises in the following cycle; no same-cycle overlap.
- res_ready high before res_valid has no effect.
- job_valid is ignored outside IDLE. Job fields are sampled only at acceptance.
- Total latency from the acceptance edge to res_valid rising is N+PE_LAT+1 cycles.
- Every output is registered; no combinational path from input to output except job_ready, which is decoded from the state register.

Optional Feature:
SUB_PE_CTRL_PERF_EN:
- When defined, adds two outputs:
  - perf_jobs[15:0]: increments on each result handshake.
  - perf_busy_cyc[31:0]: increments every cycle busy=1.
- Both counters saturate at all-ones and clear on rst.
- When undefined, these ports and their logic do not exist; the rest of the behaviour is identical.

Test Plan:
- Basic job: job_channel=3, img_base=8'h10, wgt_base=8'h20, PE_LAT=2.
  - Addresses are 10..13 and 20..23 on 4 consecutive cycles.
  - pe_start pulses once, 1 cycle after the first read.
  - res_valid rises 7 cycles after acceptance, with res_data equal to pe_result at capture.
- Minimum job: job_channel=0 -> exactly one mem_rd_en cycle, one pe_start, res_valid 4 cycles after acceptance.
- Wrap: img_base=8'hFE, job_channel=3 -> img_addr sequence FE, FF, 00, 01.
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_data stable, job_ready=0, a second job_valid is not accepted. The res_ready pulse completes the handshake and job_ready=1 the next cycle.
- Mid-job reset: assert rst during cycle 2 of FETCH (job_channel=7) -> all outputs 0 asynchronously, no res_valid afterwards. A new job then runs correctly.
- PERF_EN build: 3 back-to-back jobs with job_channel=1 and res_ready=1 -> perf_jobs=3. perf_busy_cyc equals the summed busy cycles (3×6=18).
